// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: FIFO-buffered issuer of ALU requests returning tagged results over valid/ready.
module alu_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [3:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(ALU_LAT + 1);
  localparam int EW = 20 + TAG_W;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [LW-1:0] cnt;
  logic [TAG_W-1:0] tag;
  logic full, empty, push, pop, done;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign in_ready = !full;
  assign push = in_valid && !full;
  assign done = state == WAIT && cnt == LW'(ALU_LAT);
  assign busy = !empty || state != IDLE;
  always_comb begin
    pop = !empty && (state == IDLE || (state == RESP && res_ready));
    state_nxt = pop ? WAIT : done ? RESP : (state == RESP && res_ready) ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_a, in_b, in_sel, in_tag};
  // alu_* only move on an issue edge so the ALU sees stable operands until the next pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cnt       <= '0;
      tag       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_data  <= '0;
      res_tag   <= '0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr + AW'(push);
      rd_ptr    <= rd_ptr + AW'(pop);
      count     <= count + CW'(push) - CW'(pop);
      cnt       <= pop ? '0 : state == WAIT ? cnt + 1'b1 : cnt;
      if (pop) {alu_a, alu_b, alu_sel, tag} <= mem[rd_ptr];
      if (done) begin
        res_data <= alu_out;
        res_tag  <= tag;
      end
      res_valid <= done || (res_valid && !res_ready);
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed tests of the sequencer against a small registered ALU model.
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0, in_b = '0;
  logic [3:0] in_sel = '0, in_tag = '0;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic [3:0] res_tag;
  logic       busy;
  int checks = 0;
  int errors = 0;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered ALU, no reset: add, sub, and, or, and three compare ops returning FFh/00h
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    case (s)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b1101: return (a == b) ? 8'hFF : 8'h00;
      4'b1110: return (a > b) ? 8'hFF : 8'h00;
      4'b1111: return (a < b) ? 8'hFF : 8'h00;
      default: return a ^ b;
    endcase
  endfunction
  always_ff @(posedge clk) alu_out <= alu_f(alu_a, alu_b, alu_sel);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s, input logic [3:0] t);
    in_valid = 1'b1; in_a = a; in_b = b; in_sel = s; in_tag = t;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (res_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({res_valid, busy, in_ready, alu_a, alu_b, alu_sel, res_data, res_tag} !== {1'b0, 1'b0, 1'b1, 32'h0})
      begin errors++; $display("FAIL reset_state got v=%b busy=%b rdy=%b a=%h b=%h sel=%h d=%h t=%h want 0 0 1 zeros",
        res_valid, busy, in_ready, alu_a, alu_b, alu_sel, res_data, res_tag); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    res_ready = 1'b1;
    push_op(8'h12, 8'h34, 4'h0, 4'h3);
    tick();
    checks++;
    if ({alu_a, alu_b, alu_sel, res_valid, busy} !== {8'h12, 8'h34, 4'h0, 1'b0, 1'b1})
      begin errors++; $display("FAIL add_issue got a=%h b=%h sel=%h v=%b busy=%b want 12 34 0 0 1", alu_a, alu_b, alu_sel, res_valid, busy); end
    tick();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b want 0", res_valid); end
    tick();
    checks++;
    if ({res_valid, res_data, res_tag} !== {1'b1, 8'h46, 4'h3})
      begin errors++; $display("FAIL add_result got v=%b d=%h t=%h want 1 46 3", res_valid, res_data, res_tag); end
    tick();
    checks++;
    if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL add_idle got v=%b busy=%b want 0 0", res_valid, busy); end
  endtask

  task automatic test_full();
    logic [7:0] a_t [6] = '{8'h01, 8'h10, 8'hFF, 8'h40, 8'h05, 8'hAA};
    logic [7:0] b_t [6] = '{8'h02, 8'h20, 8'h02, 8'h41, 8'h05, 8'h01};
    logic [7:0] exp [5] = '{8'h03, 8'h30, 8'h01, 8'h81, 8'h0A};
    bit ok;
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = a_t[i]; in_b = b_t[i]; in_sel = 4'h0; in_tag = 4'(i + 1);
      checks++;
      if (in_ready !== (i < 5)) begin errors++; $display("FAIL full_in_ready[%0d] got %b want %b", i, in_ready, i < 5); end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_after got in_ready=%b want 0", in_ready); end
    res_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_res(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL full_timeout[%0d] got no res_valid want res_valid=1", n); end
      else if ({res_data, res_tag} !== {exp[n], 4'(n + 1)})
        begin errors++; $display("FAIL full_order[%0d] got d=%h t=%h want d=%h t=%h", n, res_data, res_tag, exp[n], 4'(n + 1)); end
      tick();
    end
    tick(); tick();
    checks++;
    if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL full_drained got v=%b busy=%b want 0 0", res_valid, busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    res_ready = 1'b0;
    push_op(8'h50, 8'h20, 4'h1, 4'hA);
    wait_res(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout got no res_valid want res_valid=1"); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({res_valid, res_data, res_tag, alu_a, alu_b, alu_sel, busy} !== {1'b1, 8'h30, 4'hA, 8'h50, 8'h20, 4'h1, 1'b1})
        begin errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h t=%h a=%h b=%h sel=%h busy=%b want 1 30 a 50 20 1 1",
          i, res_valid, res_data, res_tag, alu_a, alu_b, alu_sel, busy); end
      tick();
    end
    res_ready = 1'b1;
    tick();
    checks++;
    if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_release got v=%b busy=%b want 0 0", res_valid, busy); end
  endtask

  task automatic test_compare();
    logic [7:0] exp_t [3] = '{8'h7, 8'h8, 8'h9};
    bit ok;
    res_ready = 1'b1;
    push_op(8'h80, 8'h7F, 4'b1110, 4'h7);
    push_op(8'h5A, 8'h5A, 4'b1101, 4'h8);
    push_op(8'h01, 8'h02, 4'b1111, 4'h9);
    for (int n = 0; n < 3; n++) begin
      wait_res(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL cmp_timeout[%0d] got no res_valid want res_valid=1", n); end
      else if ({res_data, res_tag} !== {8'hFF, exp_t[n][3:0]})
        begin errors++; $display("FAIL cmp[%0d] got d=%h t=%h want d=ff t=%h", n, res_data, res_tag, exp_t[n][3:0]); end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    res_ready = 1'b1;
    push_op(8'h11, 8'h22, 4'h0, 4'h5);
    tick();
    checks++;
    if ({busy, alu_a} !== {1'b1, 8'h11}) begin errors++; $display("FAIL rmw_issue got busy=%b a=%h want 1 11", busy, alu_a); end
    rst = 1'b1;
    in_valid = 1'b1; in_a = 8'h33; in_b = 8'h44; in_tag = 4'h6;
    #1;
    checks++;
    if ({res_valid, busy, in_ready, alu_a} !== {1'b0, 1'b0, 1'b1, 8'h00})
      begin errors++; $display("FAIL rmw_async got v=%b busy=%b rdy=%b a=%h want 0 0 1 00", res_valid, busy, in_ready, alu_a); end
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL rmw_quiet[%0d] got v=%b busy=%b want 0 0", i, res_valid, busy); end
    end
  endtask

  task automatic test_back_to_back();
    int seen [3];
    int n = 0;
    res_ready = 1'b1;
    push_op(8'h01, 8'h01, 4'h0, 4'h1);
    push_op(8'h02, 8'h02, 4'h0, 4'h2);
    push_op(8'h03, 8'h03, 4'h0, 4'h3);
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (res_valid) begin
        checks++;
        if ({res_data, res_tag} !== {8'(2 * (n + 1)), 4'(n + 1)})
          begin errors++; $display("FAIL b2b_data[%0d] got d=%h t=%h want d=%h t=%h", n, res_data, res_tag, 8'(2 * (n + 1)), 4'(n + 1)); end
        seen[n] = c;
        n++;
        if (n == 3) begin
          checks++;
          if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_last got %b want 1", busy); end
        end
      end
      tick();
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL b2b_count got %0d results want 3", n); end
    else if (seen[1] - seen[0] != 3 || seen[2] - seen[1] != 3)
      begin errors++; $display("FAIL b2b_spacing got %0d,%0d want 3,3", seen[1] - seen[0], seen[2] - seen[1]); end
    checks++;
    if ({busy, res_valid} !== 2'b00) begin errors++; $display("FAIL b2b_busy_fall got busy=%b v=%b want 0 0", busy, res_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_full();
    test_backpressure();
    test_compare();
    test_reset_mid_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
